nf_gpio_irq: RTL



---
 rtl/nf_gpio_irq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/nf_gpio_irq.sv
`default_nettype none
// ============================================================================
// nf_gpio_irq : nanoFOX GPIO with input synchroniser, atomic GPO set/clear,
//               and per-pin edge/level interrupts combined onto one irq line.
// Revision    : 1.0
// ============================================================================
module nf_gpio_irq #(
  parameter int gpio_w      = 8,
  parameter int sync_stages = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [31:0]       wd,
  output logic [31:0]       rd,
  input  logic [gpio_w-1:0] gpi,
  output logic [gpio_w-1:0] gpo,
  output logic [gpio_w-1:0] gpd,
  output logic              irq
);

  localparam logic [5:0] OFF_GPI      = 6'h00;
  localparam logic [5:0] OFF_GPO      = 6'h04;
  localparam logic [5:0] OFF_DIR      = 6'h08;
  localparam logic [5:0] OFF_GPO_SET  = 6'h0C;
  localparam logic [5:0] OFF_GPO_CLR  = 6'h10;
  localparam logic [5:0] OFF_IRQ_EN   = 6'h14;
  localparam logic [5:0] OFF_IRQ_TYPE = 6'h18;
  localparam logic [5:0] OFF_IRQ_POL  = 6'h1C;
  localparam logic [5:0] OFF_IRQ_STAT = 6'h20;

  logic [gpio_w-1:0] sync_q [sync_stages];
  logic [gpio_w-1:0] gpi_s;
  logic [gpio_w-1:0] prev;
  logic [gpio_w-1:0] irq_en;
  logic [gpio_w-1:0] irq_type;
  logic [gpio_w-1:0] irq_pol;
  logic [gpio_w-1:0] irq_stat;
  logic [gpio_w-1:0] stat_next;
  logic [gpio_w-1:0] rise;
  logic [gpio_w-1:0] fall;
  logic [gpio_w-1:0] evt;
  logic [gpio_w-1:0] stat_clr;
  logic [gpio_w-1:0] wdata;
  logic [5:0]        off;
  logic              unused_bits;

  generate
    if (gpio_w < 1 || gpio_w > 32 || sync_stages < 2) begin : g_param_check
      $error("nf_gpio_irq: gpio_w must be 1..32 and sync_stages >= 2");
    end
  endgenerate

  assign off         = addr[5:0];
  assign wdata       = wd[gpio_w-1:0];
  assign unused_bits = ^{addr[31:6], wd};

  genvar s;
  generate
    for (s = 0; s < sync_stages; s++) begin : g_sync
      if (s == 0) begin : g_first
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) sync_q[s] <= '0;
          else         sync_q[s] <= gpi;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge resetn) begin
          if (!resetn) sync_q[s] <= '0;
          else         sync_q[s] <= sync_q[s-1];
        end
      end
    end
  endgenerate

  assign gpi_s = sync_q[sync_stages-1];

  assign rise     = gpi_s & ~prev;
  assign fall     = ~gpi_s & prev;
  assign evt      = (irq_pol & rise) | (~irq_pol & fall);
  assign stat_clr = (we && off == OFF_IRQ_STAT) ? wdata : '0;

  // Edge bits: a new event beats a simultaneous W1C. Level bits follow the pin.
  assign stat_next = (irq_type & ((irq_stat & ~stat_clr) | evt))
                   | (~irq_type & ~(gpi_s ^ irq_pol));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpo      <= '0;
      gpd      <= '0;
      irq_en   <= '0;
      irq_type <= '0;
      irq_pol  <= '0;
      irq_stat <= '0;
      prev     <= '0;
    end else begin
      prev     <= gpi_s;
      irq_stat <= stat_next;
      if (we) begin
        case (off)
          OFF_GPO:      gpo      <= wdata;
          OFF_DIR:      gpd      <= wdata;
          OFF_GPO_SET:  gpo      <= gpo | wdata;
          OFF_GPO_CLR:  gpo      <= gpo & ~wdata;
          OFF_IRQ_EN:   irq_en   <= wdata;
          OFF_IRQ_TYPE: irq_type <= wdata;
          OFF_IRQ_POL:  irq_pol  <= wdata;
          default:      ;
        endcase
      end
    end
  end

  assign irq = |(irq_stat & irq_en);

  always_comb begin
    rd = '0;
    case (off)
      OFF_GPI:      rd = 32'(gpi_s);
      OFF_GPO:      rd = 32'(gpo);
      OFF_DIR:      rd = 32'(gpd);
      OFF_IRQ_EN:   rd = 32'(irq_en);
      OFF_IRQ_TYPE: rd = 32'(irq_type);
      OFF_IRQ_POL:  rd = 32'(irq_pol);
      OFF_IRQ_STAT: rd = 32'(irq_stat);
      default:      rd = '0;
    endcase
  end

endmodule
`default_nettype wire
